ballot_collector: RTL and testbench

- Sequential front end of the voting machine: turns raw candidate button presses into the four per-candidate vote counts consumed by the winner/tie results logic.
- Enforces a poll session, one vote per authorised voter and a post-vote lockout.
- Rejects simultaneous multi-button presses.
- Sits between the panel buttons / poll-official controls and the results logic.

---
 rtl/ballot_collector.sv | 166 ++++++++++++++++
 tb/tb_ballot_collector.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ballot_collector.sv
// Ballot collector: synchronises candidate buttons, enforces the poll session
// and one-vote-per-authorisation, and keeps saturating per-candidate tallies.
module ballot_collector #(
    parameter int CNT_W          = 8,
    parameter int LOCKOUT_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 open_poll,
    input  logic                 close_poll,
    input  logic                 clear_counts,
    input  logic                 voter_auth,
    input  logic [3:0]           btn,
    output logic [CNT_W-1:0]     cand1,
    output logic [CNT_W-1:0]     cand2,
    output logic [CNT_W-1:0]     cand3,
    output logic [CNT_W-1:0]     cand4,
    output logic [CNT_W+1:0]     total_votes,
    output logic                 vote_ack,
    output logic                 invalid,
    output logic                 armed,
    output logic                 poll_open,
    output logic                 sat
);

    localparam int TOT_W  = CNT_W + 2;
    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W-1:0] TOT_MAX = '1;

    typedef enum logic [1:0] {
        CLOSED,
        IDLE,
        ARMED,
        COOLDOWN
    } state_t;

    state_t                     r_state;
    logic [3:0]                 r_sync1;
    logic [3:0]                 r_sync2;
    logic [3:0]                 r_prev;
    logic [LOCK_W-1:0]          r_lock;
    logic [3:0][CNT_W-1:0]      r_cnt;
    logic [TOT_W-1:0]           r_total;
    logic                       r_ack;
    logic                       r_inv;
    logic                       r_armed;
    logic                       r_poll_open;
    logic                       r_sat;

    logic [3:0]                 w_edge;
    logic                       w_one_hot;
    logic                       w_multi;

    assign w_edge    = r_sync2 & ~r_prev;
    assign w_one_hot = (w_edge != 4'd0) && ((w_edge & (w_edge - 4'd1)) == 4'd0);
    assign w_multi   = (w_edge != 4'd0) && !w_one_hot;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
        end else begin
            r_sync1 <= btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // NOTE: the tally registers are architectural outputs, so they take the
    // asynchronous reset like every other flop here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= CLOSED;
            r_lock      <= '0;
            r_cnt       <= '0;
            r_total     <= '0;
            r_ack       <= 1'b0;
            r_inv       <= 1'b0;
            r_armed     <= 1'b0;
            r_poll_open <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_inv <= 1'b0;
            case (r_state)
                CLOSED: begin
                    if (clear_counts) begin
                        r_cnt   <= '0;
                        r_total <= '0;
                        r_sat   <= 1'b0;
                    end
                    if (open_poll && !close_poll) begin
                        r_state     <= IDLE;
                        r_poll_open <= 1'b1;
                    end
                end
                IDLE: begin
                    if (close_poll) begin
                        r_state     <= CLOSED;
                        r_poll_open <= 1'b0;
                    end else if (voter_auth) begin
                        r_state <= ARMED;
                        r_armed <= 1'b1;
                    end
                end
                ARMED: begin
                    if (close_poll) begin
                        r_state     <= CLOSED;
                        r_armed     <= 1'b0;
                        r_poll_open <= 1'b0;
                    end else if (w_one_hot) begin
                        for (int i = 0; i < 4; i++) begin
                            if (w_edge[i]) begin
                                if (r_cnt[i] != CNT_MAX)
                                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                                if (r_cnt[i] >= CNT_MAX - CNT_W'(1))
                                    r_sat <= 1'b1;
                            end
                        end
                        if (r_total != TOT_MAX)
                            r_total <= r_total + TOT_W'(1);
                        if (r_total >= TOT_MAX - TOT_W'(1))
                            r_sat <= 1'b1;
                        r_ack   <= 1'b1;
                        r_armed <= 1'b0;
                        r_lock  <= LOCK_W'(LOCKOUT_CYCLES - 1);
                        r_state <= COOLDOWN;
                    end else if (w_multi) begin
                        r_inv <= 1'b1;
                    end
                end
                COOLDOWN: begin
                    if (close_poll) begin
                        r_state     <= CLOSED;
                        r_poll_open <= 1'b0;
                    end else if (r_lock == '0) begin
                        r_state <= IDLE;
                    end else begin
                        r_lock <= r_lock - LOCK_W'(1);
                    end
                end
                default: begin
                    r_state     <= CLOSED;
                    r_armed     <= 1'b0;
                    r_poll_open <= 1'b0;
                end
            endcase
        end
    end

    assign cand1       = r_cnt[0];
    assign cand2       = r_cnt[1];
    assign cand3       = r_cnt[2];
    assign cand4       = r_cnt[3];
    assign total_votes = r_total;
    assign vote_ack    = r_ack;
    assign invalid     = r_inv;
    assign armed       = r_armed;
    assign poll_open   = r_poll_open;
    assign sat         = r_sat;

endmodule

// File: tb/tb_ballot_collector.sv
// Directed bench for ballot_collector: a per-cycle vector table plus
// hand-written sequences for saturation, close-during-vote and async reset.
module tb_ballot_collector;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       open_poll, close_poll, clear_counts, voter_auth;
    logic [3:0] btn;
    logic [7:0] cand1, cand2, cand3, cand4;
    logic [9:0] total_votes;
    logic       vote_ack, invalid, armed, poll_open, sat;

    int checks   = 0;
    int failures = 0;

    ballot_collector #(.CNT_W(8), .LOCKOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .open_poll    (open_poll),
        .close_poll   (close_poll),
        .clear_counts (clear_counts),
        .voter_auth   (voter_auth),
        .btn          (btn),
        .cand1        (cand1),
        .cand2        (cand2),
        .cand3        (cand3),
        .cand4        (cand4),
        .total_votes  (total_votes),
        .vote_ack     (vote_ack),
        .invalid      (invalid),
        .armed        (armed),
        .poll_open    (poll_open),
        .sat          (sat)
    );

    always #5 clk = ~clk;

    // ctl = {open_poll, close_poll, clear_counts, voter_auth}
    // fl  = {armed, poll_open, vote_ack, invalid, sat}
    typedef struct {
        logic [3:0] ctl;
        logic [3:0] b;
        logic [4:0] fl;
        logic [7:0] c1, c2, c3, c4;
        logic [9:0] tot;
    } vec_t;

    vec_t tbl[41];

    function automatic vec_t mk(logic [3:0] ctl, logic [3:0] b, logic [4:0] fl,
                                logic [7:0] c1, logic [7:0] c2, logic [7:0] c3,
                                logic [7:0] c4, logic [9:0] tot);
        vec_t v;
        v.ctl = ctl; v.b = b; v.fl = fl;
        v.c1 = c1; v.c2 = c2; v.c3 = c3; v.c4 = c4; v.tot = tot;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] flags();
        return {armed, poll_open, vote_ack, invalid, sat};
    endfunction

    function automatic logic [41:0] counts();
        return {cand1, cand2, cand3, cand4, total_votes};
    endfunction

    // From IDLE: authorise, pulse b for one cycle, wait (bounded) for the ack,
    // optionally wait out the lockout so the machine is back in IDLE.
    task automatic do_vote(input logic [3:0] b, input bit wait_cd, output bit got);
        got = 1'b0;
        voter_auth = 1'b1; step(); voter_auth = 1'b0;
        btn = b; step(); btn = 4'd0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (vote_ack) begin
                got = 1'b1;
                break;
            end
        end
        if (wait_cd) repeat (4) step();
    endtask

    initial begin
        bit got;

        tbl[0]  = mk(4'b1000, 4'b0000, 5'b01000, 0, 0, 0, 0, 0);
        tbl[1]  = mk(4'b0001, 4'b0000, 5'b11000, 0, 0, 0, 0, 0);
        tbl[2]  = mk(4'b0000, 4'b0010, 5'b11000, 0, 0, 0, 0, 0);
        tbl[3]  = mk(4'b0000, 4'b0000, 5'b11000, 0, 0, 0, 0, 0);
        tbl[4]  = mk(4'b0000, 4'b0000, 5'b01100, 0, 1, 0, 0, 1);
        tbl[5]  = mk(4'b0001, 4'b0000, 5'b01000, 0, 1, 0, 0, 1);
        tbl[6]  = mk(4'b0000, 4'b0000, 5'b01000, 0, 1, 0, 0, 1);
        tbl[7]  = mk(4'b0001, 4'b0000, 5'b01000, 0, 1, 0, 0, 1);
        tbl[8]  = mk(4'b0001, 4'b0000, 5'b01000, 0, 1, 0, 0, 1);
        tbl[9]  = mk(4'b0001, 4'b0000, 5'b11000, 0, 1, 0, 0, 1);
        tbl[10] = mk(4'b0000, 4'b0101, 5'b11000, 0, 1, 0, 0, 1);
        tbl[11] = mk(4'b0000, 4'b0101, 5'b11000, 0, 1, 0, 0, 1);
        tbl[12] = mk(4'b0000, 4'b0101, 5'b11010, 0, 1, 0, 0, 1);
        tbl[13] = mk(4'b0000, 4'b0000, 5'b11000, 0, 1, 0, 0, 1);
        tbl[14] = mk(4'b0000, 4'b0000, 5'b11000, 0, 1, 0, 0, 1);
        tbl[15] = mk(4'b0000, 4'b0100, 5'b11000, 0, 1, 0, 0, 1);
        tbl[16] = mk(4'b0000, 4'b0000, 5'b11000, 0, 1, 0, 0, 1);
        tbl[17] = mk(4'b0000, 4'b0000, 5'b01100, 0, 1, 1, 0, 2);
        tbl[18] = mk(4'b0010, 4'b0000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[19] = mk(4'b0000, 4'b0000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[20] = mk(4'b0000, 4'b0000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[21] = mk(4'b0000, 4'b0000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[22] = mk(4'b0000, 4'b1000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[23] = mk(4'b0000, 4'b1000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[24] = mk(4'b0000, 4'b0000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[25] = mk(4'b0000, 4'b0000, 5'b01000, 0, 1, 1, 0, 2);
        tbl[26] = mk(4'b0000, 4'b0001, 5'b01000, 0, 1, 1, 0, 2);
        tbl[27] = mk(4'b0000, 4'b0001, 5'b01000, 0, 1, 1, 0, 2);
        tbl[28] = mk(4'b0000, 4'b0001, 5'b01000, 0, 1, 1, 0, 2);
        tbl[29] = mk(4'b0001, 4'b0001, 5'b11000, 0, 1, 1, 0, 2);
        tbl[30] = mk(4'b0000, 4'b0001, 5'b11000, 0, 1, 1, 0, 2);
        tbl[31] = mk(4'b0000, 4'b0001, 5'b11000, 0, 1, 1, 0, 2);
        tbl[32] = mk(4'b0000, 4'b0000, 5'b11000, 0, 1, 1, 0, 2);
        tbl[33] = mk(4'b0000, 4'b0000, 5'b11000, 0, 1, 1, 0, 2);
        tbl[34] = mk(4'b0000, 4'b0001, 5'b11000, 0, 1, 1, 0, 2);
        tbl[35] = mk(4'b0000, 4'b0000, 5'b11000, 0, 1, 1, 0, 2);
        tbl[36] = mk(4'b0000, 4'b0000, 5'b01100, 1, 1, 1, 0, 3);
        tbl[37] = mk(4'b0100, 4'b0000, 5'b00000, 1, 1, 1, 0, 3);
        tbl[38] = mk(4'b1100, 4'b0000, 5'b00000, 1, 1, 1, 0, 3);
        tbl[39] = mk(4'b0001, 4'b0000, 5'b00000, 1, 1, 1, 0, 3);
        tbl[40] = mk(4'b0010, 4'b0000, 5'b00000, 0, 0, 0, 0, 0);

        rst_n = 1'b0;
        {open_poll, close_poll, clear_counts, voter_auth} = 4'b0000;
        btn = 4'd0;
        #12;
        check("reset_flags", 64'(flags()), 64'(5'b00000));
        check("reset_counts", 64'(counts()), 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 41; i++) begin
            {open_poll, close_poll, clear_counts, voter_auth} = tbl[i].ctl;
            btn = tbl[i].b;
            step();
            check($sformatf("vec%0d_flags", i), 64'(flags()), 64'(tbl[i].fl));
            check($sformatf("vec%0d_counts", i), 64'(counts()),
                  64'({tbl[i].c1, tbl[i].c2, tbl[i].c3, tbl[i].c4, tbl[i].tot}));
        end
        {open_poll, close_poll, clear_counts, voter_auth} = 4'b0000;
        btn = 4'd0;

        // Saturation of candidate 4
        open_poll = 1'b1; step(); open_poll = 1'b0;
        for (int n = 0; n < 254; n++) do_vote(4'b1000, 1'b1, got);
        check("preload_cand4", 64'({cand4, total_votes, sat}), 64'({8'd254, 10'd254, 1'b0}));
        do_vote(4'b1000, 1'b1, got);
        check("sat_vote1_ack", 64'(got), 64'd1);
        check("sat_vote1", 64'({cand4, total_votes, sat}), 64'({8'd255, 10'd255, 1'b1}));
        do_vote(4'b1000, 1'b1, got);
        check("sat_vote2_ack", 64'(got), 64'd1);
        check("sat_vote2", 64'({cand4, total_votes, sat}), 64'({8'd255, 10'd256, 1'b1}));
        clear_counts = 1'b1; step(); clear_counts = 1'b0;
        check("clear_in_idle", 64'({cand4, total_votes, sat, poll_open}),
              64'({8'd255, 10'd256, 1'b1, 1'b1}));
        close_poll = 1'b1; step(); close_poll = 1'b0;
        check("closed_after_close", 64'(poll_open), 64'd0);
        clear_counts = 1'b1; step(); clear_counts = 1'b0;
        check("clear_in_closed", 64'({counts(), sat}), 64'd0);

        // Vote edge arriving in the same cycle as close_poll is discarded
        open_poll = 1'b1; step(); open_poll = 1'b0;
        voter_auth = 1'b1; step(); voter_auth = 1'b0;
        check("close_race_armed", 64'(armed), 64'd1);
        btn = 4'b0010; step(); btn = 4'd0;
        step();
        close_poll = 1'b1; step(); close_poll = 1'b0;
        check("close_race_flags", 64'(flags()), 64'(5'b00000));
        check("close_race_counts", 64'(counts()), 64'd0);
        step();
        check("close_race_no_late_ack", 64'({vote_ack, cand2}), 64'd0);

        // Asynchronous reset in the middle of a lockout
        open_poll = 1'b1; step(); open_poll = 1'b0;
        for (int n = 0; n < 4; n++) do_vote(4'b0001, 1'b1, got);
        do_vote(4'b0001, 1'b0, got);
        check("pre_reset_cand1", 64'({cand1, total_votes, got}), 64'({8'd5, 10'd5, 1'b1}));
        step();
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_counts", 64'(counts()), 64'd0);
        check("async_reset_flags", 64'(flags()), 64'(5'b00000));
        step();
        rst_n = 1'b1;
        voter_auth = 1'b1; step(); voter_auth = 1'b0;
        check("post_reset_closed", 64'({armed, poll_open}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
